// File: rtl/booth_pkg.sv
// booth_pkg: FSM state codes, Booth radix-4 triple codes and the triple-to-digit map.
package booth_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] T_000 = 3'b000;
    localparam logic [2:0] T_001 = 3'b001;
    localparam logic [2:0] T_010 = 3'b010;
    localparam logic [2:0] T_011 = 3'b011;
    localparam logic [2:0] T_100 = 3'b100;
    localparam logic [2:0] T_101 = 3'b101;
    localparam logic [2:0] T_110 = 3'b110;
    localparam logic [2:0] T_111 = 3'b111;

    function automatic logic signed [2:0] booth_digit(input logic [2:0] t);
        return (t == T_000 || t == T_111) ? 3'sd0 :
               (t == T_001 || t == T_010) ? 3'sd1 :
               (t == T_011)               ? 3'sd2 :
               (t == T_100)               ? -3'sd2 :
               (t == T_101 || t == T_110) ? -3'sd1 : 3'sd0;
    endfunction
endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: maps one Booth triple and the multiplicand to a signed partial product.
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int N = 28
) (
    input  logic [2:0]          i_triple,
    input  logic [N-1:0]        i_b,
    output logic signed [N+1:0] o_pp
);
    logic signed [2:0]   w_d;
    logic signed [N+1:0] w_b1;
    logic signed [N+1:0] w_b2;

    // Two extra bits let -2b stay representable even for b = -2^(N-1).
    assign w_d  = booth_digit(i_triple);
    assign w_b1 = {{2{i_b[N-1]}}, i_b};
    assign w_b2 = {i_b[N-1], i_b, 1'b0};
    assign o_pp = (w_d == 3'sd1)  ? w_b1 :
                  (w_d == 3'sd2)  ? w_b2 :
                  (w_d == -3'sd1) ? -w_b1 :
                  (w_d == -3'sd2) ? -w_b2 : '0;
endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul: sequential radix-4 Booth multiplier, one digit per clock,
// valid/ready handshakes on both the operand and the product side.
module booth_seq_mul
    import booth_pkg::*;
#(
    parameter int N = 28,
    parameter int M = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] out_p
);
    localparam int IW = $clog2(M / 2);
    localparam logic [IW-1:0] LAST = IW'(M / 2 - 1);

    logic [1:0]          r_state;
    logic [M-1:0]        r_a;
    logic [N-1:0]        r_b;
    logic [N+M-1:0]      r_acc;
    logic [IW-1:0]       r_i;
    logic [M:0]          w_ax;
    logic [2:0]          w_triple;
    logic signed [N+1:0] w_pp;
    logic [N+M-1:0]      w_pp_ext;

    // Appending a zero below the LSB supplies a[-1] for the first triple.
    assign w_ax     = {r_a, 1'b0};
    assign w_triple = 3'(w_ax >> {r_i, 1'b0});
    assign w_pp_ext = {{(M - 2){w_pp[N+1]}}, w_pp} << {r_i, 1'b0};

    booth_pp_sel #(.N(N)) u_pp_sel (
        .i_triple (w_triple),
        .i_b      (r_b),
        .o_pp     (w_pp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_i     <= '0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_a     <= in_a;
                r_b     <= in_b;
                r_acc   <= '0;
                r_i     <= '0;
                r_state <= S_CALC;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= r_acc + w_pp_ext;
            r_i   <= r_i + IW'(1);
            if (r_i == LAST)
                r_state <= S_DONE;
        end else if (r_state == S_DONE) begin
            if (out_ready)
                r_state <= S_IDLE;
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_p     = r_acc;
endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul: directed and randomised checks of booth_seq_mul at N=28, M=16.
module tb_booth_seq_mul;
    localparam int N = 28;
    localparam int M = 16;
    localparam int W = N + M;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [M-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_p;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    booth_seq_mul #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait (bounded) for out_valid; lat = -1 on timeout.
    task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b, output int lat);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 16'd3;
        in_b = 28'd3;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_p !== '0) $display("FAIL reset_out_p: got %h want 0", out_p); else passed++;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_basic();
        int lat;
        run_op(16'd3, 28'd5, lat);
        total++; if (lat !== 8) $display("FAIL basic_latency: got %0d want 8", lat); else passed++;
        total++; if (out_p !== 44'd15) $display("FAIL basic_product: got %h want %h", out_p, 44'd15); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done: got %b want 0", in_ready); else passed++;
        consume();
        total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_after: got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_after: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_signs();
        int lat;
        run_op(16'hFFFF, 28'hFFFFFFF, lat);
        total++; if (out_p !== 44'd1) $display("FAIL neg1_neg1: got %h want %h", out_p, 44'd1); else passed++;
        consume();
        run_op(16'h8000, 28'd1, lat);
        total++; if (out_p !== 44'hFFFFFFF8000) $display("FAIL minA_times_1: got %h want %h", out_p, 44'hFFFFFFF8000); else passed++;
        consume();
    endtask

    task automatic test_extreme();
        int lat;
        run_op(16'h8000, 28'h8000000, lat);
        total++; if (lat !== 8) $display("FAIL extreme_latency: got %0d want 8", lat); else passed++;
        total++; if (out_p !== 44'h40000000000) $display("FAIL extreme_product: got %h want %h", out_p, 44'h40000000000); else passed++;
        consume();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_p;
        int lat;
        exp_p = 44'h2AAA8000000 - 44'd21845;
        in_a = 16'h5555;
        in_b = 28'h7FFFFFF;
        in_valid = 1'b1;
        tick();
        // Fresh operands offered mid-calculation must not be taken.
        in_a = 16'h1111;
        in_b = 28'h0000123;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        total++; if (lat !== 8) $display("FAIL bp_latency: got %0d want 8", lat); else passed++;
        for (int k = 0; k < 5; k++) begin
            total++; if (out_p !== exp_p) $display("FAIL bp_hold_product c%0d: got %h want %h", k, out_p, exp_p); else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready c%0d: got %b want 0", k, in_ready); else passed++;
            total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_out_valid c%0d: got %b want 1", k, out_valid); else passed++;
            tick();
        end
        in_valid = 1'b0;
        consume();
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_reset_abort();
        int lat;
        bit seen;
        in_a = 16'h1234;
        in_b = 28'd99;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_p !== '0) $display("FAIL abort_out_p: got %h want 0", out_p); else passed++;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) $display("FAIL abort_no_out_valid: got %b want 0", seen); else passed++;
        run_op(16'd7, 28'hFFFFFFE, lat);
        total++; if (lat !== 8) $display("FAIL abort_next_latency: got %0d want 8", lat); else passed++;
        total++; if (out_p !== 44'hFFFFFFFFFF2) $display("FAIL abort_next_product: got %h want %h", out_p, 44'hFFFFFFFFFF2); else passed++;
        consume();
    endtask

    task automatic test_back_to_back();
        logic [M-1:0] av [3];
        logic [N-1:0] bv [3];
        logic [W-1:0] ev [3];
        int na, nd, cyc;
        bit ovl, acc, del;
        av = '{16'd2, 16'hFFFD, 16'd100};
        bv = '{28'd3, 28'd4, 28'hFFFFFFB};
        ev = '{44'd6, 44'hFFFFFFFFFF4, 44'hFFFFFFFFE0C};
        na = 0; nd = 0; cyc = 0; ovl = 1'b0;
        out_ready = 1'b1;
        while (nd < 3 && cyc < 100) begin
            in_valid = (na < 3);
            if (na < 3) begin
                in_a = av[na];
                in_b = bv[na];
            end
            if (in_ready && out_valid) ovl = 1'b1;
            acc = in_valid && in_ready;
            del = out_valid;
            if (del) begin
                total++; if (out_p !== ev[nd]) $display("FAIL b2b_product %0d: got %h want %h", nd, out_p, ev[nd]); else passed++;
                nd++;
            end
            tick();
            cyc++;
            if (acc) na++;
            if (del) begin
                total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_after_deliver %0d: got %b want 1", nd, in_ready); else passed++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (nd !== 3) $display("FAIL b2b_deliveries: got %0d want 3", nd); else passed++;
        total++; if (ovl !== 1'b0) $display("FAIL b2b_accept_and_deliver_overlap: got %b want 0", ovl); else passed++;
    endtask

    task automatic test_random();
        logic [W-1:0] q [$];
        logic signed [W-1:0] ea, eb;
        logic [W-1:0] exp_p;
        int na, nd, cyc, extra;
        na = 0; nd = 0; cyc = 0; extra = 0;
        while ((na < 1000 || q.size() > 0) && cyc < 40000) begin
            in_valid = (na < 1000) && ($urandom_range(0, 1) == 1);
            in_a = M'($urandom);
            in_b = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) begin
                ea = $signed(in_a);
                eb = $signed(in_b);
                q.push_back(ea * eb);
                na++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    exp_p = q.pop_front();
                    total++; if (out_p !== exp_p) $display("FAIL rand_product %0d: got %h want %h", nd, out_p, exp_p); else passed++;
                end
                nd++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (nd !== 1000) $display("FAIL rand_delivered: got %0d want 1000", nd); else passed++;
        total++; if (extra !== 0) $display("FAIL rand_duplicates: got %0d want 0", extra); else passed++;
        total++; if (q.size() !== 0) $display("FAIL rand_pending: got %0d want 0", q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_extreme();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
